// File: rtl/instr_fetch.sv
// instr_fetch: PC register and req/ready instruction fetch feeding the decoder.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, nextState;
  logic [31:0] fetchPc;
  logic xfer, consume;
  assign xfer = state == REQ && imem_ready;
  assign consume = state == HOLD && !stall;
  assign imem_addr = fetchPc;
  assign pc_plus4 = pc + 32'd4;
  assign opcode = instr[31:26];
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = REQ;
      REQ: nextState = imem_ready ? HOLD : REQ;
      HOLD: nextState = stall ? HOLD : REQ;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetchPc <= RESET_PC;
      imem_req <= 1'b0;
      instr <= '0;
      instr_valid <= 1'b0;
      pc <= RESET_PC;
    end else begin
      state <= nextState;
      imem_req <= nextState == REQ;
      if (xfer) begin
        instr <= imem_rdata;
        pc <= fetchPc;
        instr_valid <= 1'b1;
      end
      if (consume) begin
        instr_valid <= 1'b0;
        // misaligned targets are silently word-aligned
        fetchPc <= branch_taken ? (branch_target & ~32'd3) : pc_plus4;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table, wrap/reset sequences and a randomized model check.
module tb_instr_fetch;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;
  logic clk = 1'b0;
  logic rst = 1'b1, imem_ready = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] imem_rdata = '0, branch_target = '0;
  logic imem_req, instr_valid, imem_req2, instr_valid2;
  logic [31:0] imem_addr, instr, pc, pc_plus4, imem_addr2, instr2, pc2, pc_plus42;
  logic [5:0] opcode, opcode2;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr(instr),
    .instr_valid(instr_valid), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4));
  instr_fetch #(.RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr(instr2),
    .instr_valid(instr_valid2), .opcode(opcode2), .pc(pc2), .pc_plus4(pc_plus42));
  // Transaction-level reference: one outstanding request or one presented instruction.
  logic mStart = 1'b0, mReq = 1'b0, mValid = 1'b0;
  logic [31:0] mNext = RPC, mPc = RPC, mInstr = '0;
  always @(posedge clk) begin
    if (rst) begin
      mStart = 1'b1; mReq = 1'b0; mValid = 1'b0; mNext = RPC; mPc = RPC; mInstr = '0;
    end else if (mStart) begin
      mStart = 1'b0; mReq = 1'b1;
    end else if (mReq && imem_ready) begin
      mReq = 1'b0; mValid = 1'b1; mInstr = imem_rdata; mPc = mNext;
    end else if (mValid && !stall) begin
      mValid = 1'b0; mReq = 1'b1;
      mNext = branch_taken ? {branch_target[31:2], 2'b00} : mPc + 32'd4;
    end
  end
  typedef struct {
    logic rst, rdy, stl, bt;
    logic [31:0] tgt, rd;
    logic eReq;
    logic [31:0] eAddr;
    logic eValid;
    logic [31:0] eInstr, ePc;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic add(input logic r, rdy, stl, bt, input logic [31:0] tgt, rd,
                     input logic eReq, input logic [31:0] eAddr, input logic eValid,
                     input logic [31:0] eInstr, ePc);
    vecs.push_back('{r, rdy, stl, bt, tgt, rd, eReq, eAddr, eValid, eInstr, ePc});
  endtask
  task automatic step(input logic r, rdy, stl, bt, input logic [31:0] tgt, rd);
    rst = r; imem_ready = rdy; stall = stl; branch_taken = bt;
    branch_target = tgt; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask
  initial begin
    add(1,0,0,0, 0, 0,                 0, RPC,            0, 0, RPC);
    add(0,1,0,0, 0, 32'h1111_1111,     1, RPC,            0, 0, RPC);
    add(0,1,0,0, 0, 32'h2001_0001,     0, RPC,            1, 32'h2001_0001, RPC);
    add(0,1,0,0, 0, 0,                 1, 32'h0040_0004,  0, 32'h2001_0001, RPC);
    add(0,1,0,0, 0, 32'h2002_0002,     0, 32'h0040_0004,  1, 32'h2002_0002, 32'h0040_0004);
    add(0,1,0,0, 0, 0,                 1, 32'h0040_0008,  0, 32'h2002_0002, 32'h0040_0004);
    for (int i = 0; i < 3; i++)
      add(0,0,0,1, 32'h0000_0040, 32'hAAAA_AAAA, 1, 32'h0040_0008, 0, 32'h2002_0002, 32'h0040_0004);
    add(0,1,0,0, 0, 32'h8C22_0004,     0, 32'h0040_0008,  1, 32'h8C22_0004, 32'h0040_0008);
    for (int i = 0; i < 5; i++)
      add(0,1,1,1, 32'h1234_5678, 32'h5555_5555, 0, 32'h0040_0008, 1, 32'h8C22_0004, 32'h0040_0008);
    add(0,1,0,0, 0, 0,                 1, 32'h0040_000C,  0, 32'h8C22_0004, 32'h0040_0008);
    add(0,1,0,0, 0, 32'h1022_0003,     0, 32'h0040_000C,  1, 32'h1022_0003, 32'h0040_000C);
    add(0,1,0,1, 32'h0040_0103, 0,     1, 32'h0040_0100,  0, 32'h1022_0003, 32'h0040_000C);
    add(0,1,0,0, 0, 32'h0000_0020,     0, 32'h0040_0100,  1, 32'h0000_0020, 32'h0040_0100);
    add(0,0,0,0, 0, 0,                 1, 32'h0040_0104,  0, 32'h0000_0020, 32'h0040_0100);
    add(1,0,0,0, 0, 0,                 0, RPC,            0, 0, RPC);
    add(0,1,0,0, 0, 32'hDEAD_BEEF,     1, RPC,            0, 0, RPC);
    add(0,1,0,0, 0, 32'h0123_4567,     0, RPC,            1, 32'h0123_4567, RPC);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].stl, vecs[i].bt, vecs[i].tgt, vecs[i].rd);
      chk($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].eReq));
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eAddr);
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].eValid));
      chk($sformatf("v%0d instr", i), instr, vecs[i].eInstr);
      chk($sformatf("v%0d pc", i), pc, vecs[i].ePc);
      chk($sformatf("v%0d pc_plus4", i), pc_plus4, vecs[i].ePc + 32'd4);
      chk($sformatf("v%0d opcode", i), 32'(opcode), 32'(vecs[i].eInstr >> 26));
      if (i == 9) chk("lw opcode", 32'(opcode), 32'h23);
    end
    // PC wrap from the top of the address space
    step(1,0,0,0, 0, 0);
    chk("wrap reset addr", imem_addr2, RPC2);
    chk("wrap reset pc_plus4", pc_plus42, 32'h0);
    step(0,1,0,0, 0, 32'hFFFF_0000);
    chk("wrap req", 32'(imem_req2), 32'd1);
    step(0,1,0,0, 0, 32'hFFFF_0000);
    chk("wrap valid", 32'(instr_valid2), 32'd1);
    chk("wrap pc", pc2, RPC2);
    chk("wrap opcode", 32'(opcode2), 32'h3F);
    step(0,1,0,0, 0, 0);
    chk("wrap second addr", imem_addr2, 32'h0);
    chk("wrap second req", 32'(imem_req2), 32'd1);
    // Randomized run against the reference model
    step(1,0,0,0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           1'($urandom), $urandom, $urandom);
      chk($sformatf("rnd%0d imem_req", n), 32'(imem_req), 32'(mReq));
      if (mReq) chk($sformatf("rnd%0d imem_addr", n), imem_addr, mNext);
      chk($sformatf("rnd%0d instr_valid", n), 32'(instr_valid), 32'(mValid));
      chk($sformatf("rnd%0d instr", n), instr, mInstr);
      chk($sformatf("rnd%0d pc", n), pc, mPc);
      chk($sformatf("rnd%0d pc_plus4", n), pc_plus4, mPc + 32'd4);
      chk($sformatf("rnd%0d opcode", n), 32'(opcode), 32'(mInstr[31:26]));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
